// File: rtl/matmat_sequencer.sv
// matmat_sequencer: streams A then B into a matmatN core, launches it, then streams the product out
// Ports:
//   clk, rst (synchronous, active-low)
//   in_valid/in_ready/in_data     : serial element input, A[0..N*N-1] then B[0..N*N-1]
//   out_valid/out_ready/out_data  : serial product output; out_last marks element N*N-1
//   out_err                       : job timed out (only with MATMAT_SEQ_TIMEOUT_EN, else 0)
//   mm_go/mm_ready/mm_complete    : matmatN start handshake and completion
//   mm_a, mm_b, mm_mul            : flat operands/product, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy                          : high unless idle in LOAD_A at index 0
// Optional feature: define MATMAT_SEQ_TIMEOUT_EN for a TIMEOUT_CYCLES watchdog on LAUNCH+WAIT_DONE.
module matmat_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int BIN_POS        = 8,
    parameter int MATRIX_SIZE    = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [DATA_WIDTH-1:0]                           in_data,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [DATA_WIDTH-1:0]                           out_data,
    output logic                                            out_last,
    output logic                                            out_err,
    output logic                                            mm_go,
    input  logic                                            mm_ready,
    input  logic                                            mm_complete,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   mm_a,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   mm_b,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   mm_mul,
    output logic                                            busy
);
    localparam int NN = MATRIX_SIZE * MATRIX_SIZE;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam int FW = NN * DATA_WIDTH;
    localparam logic [IW-1:0] LAST = IW'(NN - 1);

    // BIN_POS belongs to the core; it is only sanity-checked here.
    if (BIN_POS < 0 || BIN_POS >= DATA_WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("matmat_sequencer: BIN_POS or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [2:0] {LOAD_A, LOAD_B, LAUNCH, WAIT_DONE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d, idx_inc;
    logic [FW-1:0]         a_q, a_d, b_q, b_d, res_q, res_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  mm_go_q, mm_go_d;
    logic                  busy_q, busy_d;
    logic                  in_hs, out_hs;
`ifdef MATMAT_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        in_hs   = in_valid && in_ready_q;
        out_hs  = out_valid_q && out_ready;
        idx_inc = idx_q + 1'b1;
`ifdef MATMAT_SEQ_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            LOAD_A: if (in_hs) begin
                a_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = in_data;
                idx_d   = (idx_q == LAST) ? '0 : idx_inc;
                state_d = (idx_q == LAST) ? LOAD_B : LOAD_A;
            end
            LOAD_B: if (in_hs) begin
                b_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = in_data;
                idx_d   = (idx_q == LAST) ? '0 : idx_inc;
                state_d = (idx_q == LAST) ? LAUNCH : LOAD_B;
            end
            LAUNCH:    state_d = mm_ready ? WAIT_DONE : LAUNCH;
            // Completion is only trusted here so a leftover pulse during LAUNCH is dropped.
            WAIT_DONE: if (mm_complete) begin
                res_d   = mm_mul;
                idx_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: if (out_hs) begin
                idx_d   = (idx_q == LAST) ? '0 : idx_inc;
                state_d = (idx_q == LAST) ? LOAD_A : DRAIN;
            end
            default: state_d = LOAD_A;
        endcase
`ifdef MATMAT_SEQ_TIMEOUT_EN
        // Counts from 0 on the first LAUNCH cycle; an expired job drains N*N zeros with out_err set.
        wd_d = (state_q == LAUNCH || state_q == WAIT_DONE) ? wd_q + 1'b1 : '0;
        if ((state_q == LAUNCH || state_q == WAIT_DONE) && state_d != DRAIN && wd_q == WD_MAX) begin
            state_d = DRAIN;
            res_d   = '0;
            idx_d   = '0;
            err_d   = 1'b1;
        end
        if (state_d == LOAD_A) err_d = 1'b0;
`endif
        in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
        out_valid_d = state_d == DRAIN;
        out_last_d  = (state_d == DRAIN) && (idx_d == LAST);
        out_data_d  = res_d[idx_d*DATA_WIDTH +: DATA_WIDTH];
        mm_go_d     = state_d == LAUNCH;
        busy_d      = !((state_d == LOAD_A) && (idx_d == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= LOAD_A;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            mm_go_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MATMAT_SEQ_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            mm_go_q     <= mm_go_d;
            busy_q      <= busy_d;
`ifdef MATMAT_SEQ_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign mm_go     = mm_go_q;
    assign mm_a      = a_q;
    assign mm_b      = b_q;
    assign busy      = busy_q;
`ifdef MATMAT_SEQ_TIMEOUT_EN
    assign out_err   = err_q;
`else
    assign out_err   = 1'b0;
`endif
endmodule

// File: tb/tb_matmat_sequencer.sv
// tb_matmat_sequencer: directed checks of matmat_sequencer (N=2) against a behavioural matmat2 stub
module tb_matmat_sequencer;
    localparam int DW = 16;
    localparam int N  = 2;
    localparam int NN = N * N;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last, out_err, mm_go, busy;
    logic          mm_ready = 1'b0;
    logic          mm_complete = 1'b0;
    logic [NN*DW-1:0] mm_a, mm_b;
    logic [NN*DW-1:0] mm_mul = '0;

    int total = 0;
    int bad = 0;
    int go_pulses = 0;
    logic go_prev = 1'b0;
    bit core_hang = 1'b0;
    logic core_run = 1'b0;
    int core_cnt = 0;

    matmat_sequencer #(.DATA_WIDTH(DW), .BIN_POS(8), .MATRIX_SIZE(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_err(out_err), .mm_go(mm_go), .mm_ready(mm_ready), .mm_complete(mm_complete),
        .mm_a(mm_a), .mm_b(mm_b), .mm_mul(mm_mul), .busy(busy)
    );

    always #5 clk = ~clk;

    // Golden Q8 fixed-point product, row-major, element i at [i*DW +: DW].
    function automatic logic [NN*DW-1:0] matmul(input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b);
        logic [NN*DW-1:0] c;
        logic signed [2*DW+1:0] acc;
        c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int k = 0; k < N; k++)
                    acc += $signed(a[(i*N+k)*DW +: DW]) * $signed(b[(k*N+j)*DW +: DW]);
                c[(i*N+j)*DW +: DW] = DW'(acc >>> 8);
            end
        end
        return c;
    endfunction

    // matmat2 stand-in: ready one cycle after go, complete a few cycles after acceptance.
    always @(posedge clk) begin
        go_prev <= mm_go;
        if (mm_go && !go_prev) go_pulses <= go_pulses + 1;
        if (!rst) begin
            mm_ready    <= 1'b0;
            mm_complete <= 1'b0;
            core_run    <= 1'b0;
            core_cnt    <= 0;
        end else begin
            mm_ready    <= mm_go;
            mm_complete <= 1'b0;
            if (mm_go && mm_ready) begin
                core_run <= 1'b1;
                core_cnt <= 0;
            end else if (core_run && !core_hang) begin
                core_cnt <= core_cnt + 1;
                if (core_cnt == 2) begin
                    mm_mul      <= matmul(mm_a, mm_b);
                    mm_complete <= 1'b1;
                    core_run    <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the handshake.
    task automatic push(input logic [DW-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_rdy", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_job(input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b);
        for (int i = 0; i < NN; i++) push(a[i*DW +: DW]);
        for (int i = 0; i < NN; i++) push(b[i*DW +: DW]);
    endtask

    task automatic drain(input string tag, input logic [NN*DW-1:0] e, input logic err);
        int n;
        out_ready = 1'b1;
        for (int k = 0; k < NN; k++) begin
            n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_data"}, out_data, e[k*DW +: DW]);
            chk({tag, "_last"}, out_last, (k == NN - 1) ? 1 : 0);
            chk({tag, "_err"}, out_err, err);
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        logic [NN*DW-1:0] a_id, b1, a_two, b_half, e_two, ra[3], rb[3];
        logic [DW-1:0] prev_d;
        logic tgl, prev_stall;
        int k, n, extra, go0;
        a_id   = 64'h0100_0000_0000_0100;
        b1     = 64'h0500_0400_0300_0200;
        a_two  = {4{16'h0200}};
        b_half = {4{16'h0080}};
        e_two  = {4{16'h0200}};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_mm_go", mm_go, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mm_a", mm_a, 0);
        chk("rst_mm_b", mm_b, 0);
        rst = 1'b1;

        // 1 identity
        load_job(a_id, b1);
        in_valid = 1'b0;
        chk("t1_go", mm_go, 1);
        chk("t1_in_ready", in_ready, 0);
        chk("t1_busy", busy, 1);
        chk("t1_mm_a", mm_a, a_id);
        chk("t1_mm_b", mm_b, b1);
        drain("t1", b1, 1'b0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_in_ready", in_ready, 1);
        chk("t1_idle_out_valid", out_valid, 0);

        // 2 backpressure
        load_job(a_id, b1);
        in_valid = 1'b0;
        k = 0; n = 0; tgl = 1'b1; prev_stall = 1'b0; prev_d = '0;
        while (k < NN && n < 200) begin
            out_ready = tgl;
            tgl = ~tgl;
            if (out_valid) begin
                if (prev_stall) chk("t2_hold", out_data, prev_d);
                if (out_ready) begin
                    chk("t2_data", out_data, b1[k*DW +: DW]);
                    chk("t2_in_ready", in_ready, 0);
                    k++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            @(negedge clk);
            n++;
        end
        chk("t2_handshakes", k, NN);
        out_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            if (out_valid) extra++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("t2_extra", extra, 0);
        chk("t2_in_ready_after", in_ready, 1);

        // 3 scale
        load_job(a_two, b_half);
        in_valid = 1'b0;
        drain("t3", e_two, 1'b0);

        // 4 reset mid-job
        push(16'h0100);
        push(16'h0000);
        push(16'h0000);
        in_valid = 1'b0;
        chk("t4_busy_mid", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t4_in_ready", in_ready, 1);
        chk("t4_mm_go", mm_go, 0);
        chk("t4_busy", busy, 0);
        chk("t4_mm_a", mm_a, 0);
        load_job(a_id, b1);
        in_valid = 1'b0;
        drain("t4", b1, 1'b0);

        // 5 back-to-back random jobs, in_valid held high
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < NN; i++) begin
                ra[j][i*DW +: DW] = DW'($urandom_range(0, 32'h13FE) - 32'h9FF);
                rb[j][i*DW +: DW] = DW'($urandom_range(0, 32'h13FE) - 32'h9FF);
            end
        end
        go0 = go_pulses;
        fork
            begin
                for (int j = 0; j < 3; j++) load_job(ra[j], rb[j]);
                in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 3; j++) drain("t5", matmul(ra[j], rb[j]), 1'b0);
            end
        join
        chk("t5_go_pulses", go_pulses - go0, 3);
        chk("t5_busy", busy, 0);

`ifdef MATMAT_SEQ_TIMEOUT_EN
        // 6 watchdog
        core_hang = 1'b1;
        load_job(a_id, b1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_cycles", n, TO);
        chk("t6_mm_go", mm_go, 0);
        drain("t6", '0, 1'b1);
        chk("t6_err_clear", out_err, 0);
        chk("t6_in_ready", in_ready, 1);
        core_hang = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
